// File: rtl/alu_seq_if.sv
// Request, result and Alu-side signals of the pass sequencer.
// slave: the sequencer; master: decoder plus the combinational Alu.
interface alu_seq_if;
    logic       start;
    logic [4:0] op;
    logic [7:0] a_lo;
    logic [7:0] a_hi;
    logic [7:0] b_in;
    logic       flags_we;
    logic [7:0] flags_in;
    logic       busy;
    logic       done;
    logic       wr_lo;
    logic       wr_hi;
    logic [7:0] res_lo;
    logic [7:0] res_hi;
    logic [7:0] flags;
    logic [4:0] alu_mode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_flags;
    logic [7:0] alu_out;
    logic [7:0] alu_out_flags;

    modport slave (
        input  start, op, a_lo, a_hi, b_in, flags_we, flags_in, alu_out, alu_out_flags,
        output busy, done, wr_lo, wr_hi, res_lo, res_hi, flags,
               alu_mode, alu_a, alu_b, alu_flags
    );

    modport master (
        output start, op, a_lo, a_hi, b_in, flags_we, flags_in, alu_out, alu_out_flags,
        input  busy, done, wr_lo, wr_hi, res_lo, res_hi, flags,
               alu_mode, alu_a, alu_b, alu_flags
    );
endinterface

// File: rtl/alu_seq.sv
// ALU pass sequencer: latency 2 (single pass) or 3 (INCW/DECW, and DA when ALU_SEQ_DA_EN is defined).
// No backpressure: start is sampled only while idle and is never queued; owns the flag register.
module alu_seq (
    input  logic       clk,
    input  logic       reset_n,
    alu_seq_if.slave   bus
);
    localparam logic [4:0] ALU1_LD   = 5'h00;
    localparam logic [4:0] ALU1_INC  = 5'h01;
    localparam logic [4:0] ALU1_DEC  = 5'h02;
    localparam logic [4:0] ALU1_INCW = 5'h03;
    localparam logic [4:0] ALU1_DECW = 5'h04;
    localparam logic [4:0] ALU1_DA_H = 5'h06;
    localparam logic [4:0] ALU2_CP   = 5'h11;
    localparam logic [4:0] ALU2_TM   = 5'h12;
    localparam logic [4:0] ALU2_TCM  = 5'h13;

    typedef enum logic [1:0] {IDLE = 2'd0, P1 = 2'd1, P2 = 2'd2, FIN = 2'd3} state_t;

    state_t     state;
    logic [4:0] op_q;
    logic [7:0] a_lo_q, a_hi_q, b_q;
    logic [7:0] tmp, tflags;
    logic       busy_q, done_q, wr_lo_q, wr_hi_q;
    logic [7:0] res_lo_q, res_hi_q, flags_q;

    logic is_word, is_da2, two_pass, flags_only;

    assign is_word    = (op_q == ALU1_INCW) || (op_q == ALU1_DECW);
`ifdef ALU_SEQ_DA_EN
    localparam logic [4:0] ALU1_DA = 5'h05;
    assign is_da2     = (op_q == ALU1_DA);
`else
    assign is_da2     = 1'b0;
`endif
    assign two_pass   = is_word || is_da2;
    assign flags_only = (op_q == ALU2_CP) || (op_q == ALU2_TM) || (op_q == ALU2_TCM);

    always_comb begin
        bus.alu_mode  = ALU1_LD;
        bus.alu_a     = bus.a_lo;
        bus.alu_b     = 8'h00;
        bus.alu_flags = flags_q;
        case (state)
            P1: begin
                bus.alu_a = a_lo_q;
                if (op_q == ALU1_INCW)      bus.alu_mode = ALU1_INC;
                else if (op_q == ALU1_DECW) bus.alu_mode = ALU1_DEC;
                else begin
                    bus.alu_mode = op_q;
                    bus.alu_b    = b_q;
                end
            end
            P2: begin
                // Second pass carries the pass-1 flags so the Alu sees the low-half outcome.
                bus.alu_flags = tflags;
                if (is_word) begin
                    bus.alu_mode = op_q;
                    bus.alu_a    = a_hi_q;
                    bus.alu_b    = tmp;
                end else begin
                    bus.alu_mode = ALU1_DA_H;
                    bus.alu_a    = tmp;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            op_q     <= 5'h00;
            a_lo_q   <= 8'h00;
            a_hi_q   <= 8'h00;
            b_q      <= 8'h00;
            tmp      <= 8'h00;
            tflags   <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_lo_q  <= 1'b0;
            wr_hi_q  <= 1'b0;
            res_lo_q <= 8'h00;
            res_hi_q <= 8'h00;
            flags_q  <= 8'h00;
        end else begin
            done_q  <= 1'b0;
            wr_lo_q <= 1'b0;
            wr_hi_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        a_lo_q <= bus.a_lo;
                        a_hi_q <= bus.a_hi;
                        b_q    <= bus.b_in;
                        busy_q <= 1'b1;
                        state  <= P1;
                    end
                end
                P1: begin
                    tmp    <= bus.alu_out;
                    tflags <= bus.alu_out_flags;
                    if (two_pass) begin
                        state <= P2;
                    end else begin
                        state    <= FIN;
                        flags_q  <= bus.alu_out_flags;
                        res_lo_q <= bus.alu_out;
                        done_q   <= 1'b1;
                        wr_lo_q  <= !flags_only;
                    end
                end
                P2: begin
                    state   <= FIN;
                    flags_q <= bus.alu_out_flags;
                    done_q  <= 1'b1;
                    wr_lo_q <= 1'b1;
                    wr_hi_q <= is_word;
                    if (is_word) begin
                        res_lo_q <= tmp;
                        res_hi_q <= bus.alu_out;
                    end else begin
                        res_lo_q <= bus.alu_out;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // A CPU write to the flag register overrides any sequencer update in the same cycle.
            if (bus.flags_we) flags_q <= bus.flags_in;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.wr_lo  = wr_lo_q;
    assign bus.wr_hi  = wr_hi_q;
    assign bus.res_lo = res_lo_q;
    assign bus.res_hi = res_hi_q;
    assign bus.flags  = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a small behavioural Alu; honours ALU_SEQ_DA_EN.
module tb_alu_seq;
    localparam logic [4:0] ALU1_LD   = 5'h00;
    localparam logic [4:0] ALU1_INC  = 5'h01;
    localparam logic [4:0] ALU1_DEC  = 5'h02;
    localparam logic [4:0] ALU1_INCW = 5'h03;
    localparam logic [4:0] ALU1_DECW = 5'h04;
    localparam logic [4:0] ALU1_DA   = 5'h05;
    localparam logic [4:0] ALU1_DA_H = 5'h06;
    localparam logic [4:0] ALU2_ADD  = 5'h10;
    localparam logic [4:0] ALU2_CP   = 5'h11;
    localparam logic [4:0] ALU2_TM   = 5'h12;
    localparam logic [4:0] ALU2_TCM  = 5'h13;
    localparam int FC = 7, FZ = 6, FS = 5, FV = 4, FD = 3, FH = 2;

`ifdef ALU_SEQ_DA_EN
    localparam int         DA_LAT   = 3;
    localparam logic [7:0] DA9A_RES = 8'h00;
    localparam logic [7:0] DA9A_FLG = 8'hC0;
`else
    localparam int         DA_LAT   = 2;
    localparam logic [7:0] DA9A_RES = 8'hA0;
    localparam logic [7:0] DA9A_FLG = 8'h20;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_seq_if bus ();
    alu_seq dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    logic [8:0] m_sum;
    logic [4:0] m_h;
    logic [7:0] m_r, m_f;
    logic [7:0] ma, mb;

    // Behavioural Alu; flag layout C Z S V D H in bits 7..2.
    always_comb begin
        ma    = bus.alu_a;
        mb    = bus.alu_b;
        m_sum = 9'd0;
        m_h   = 5'd0;
        m_r   = ma;
        m_f   = bus.alu_flags;
        case (bus.alu_mode)
            ALU1_LD: ;
            ALU1_INC: begin m_r = ma + 8'd1; m_f[FV] = (ma == 8'h7F); end
            ALU1_DEC: begin m_r = ma - 8'd1; m_f[FV] = (ma == 8'h80); end
            ALU1_INCW: begin
                m_r = ma + {7'd0, mb == 8'h00};
                m_f[FV] = (ma == 8'h7F) && (mb == 8'h00);
            end
            ALU1_DECW: begin
                m_r = ma - {7'd0, mb == 8'hFF};
                m_f[FV] = (ma == 8'h80) && (mb == 8'hFF);
            end
            ALU1_DA: begin
                m_sum = {1'b0, ma} + (((ma[3:0] > 4'd9) || bus.alu_flags[FH]) ? 9'h006 : 9'h000);
                m_r = m_sum[7:0];
                m_f[FC] = bus.alu_flags[FC] | m_sum[8];
            end
            ALU1_DA_H: begin
                m_sum = {1'b0, ma} + (((ma[7:4] > 4'd9) || bus.alu_flags[FC]) ? 9'h060 : 9'h000);
                m_r = m_sum[7:0];
                m_f[FC] = bus.alu_flags[FC] | m_sum[8] | (ma[7:4] > 4'd9);
            end
            ALU2_ADD: begin
                m_sum = {1'b0, ma} + {1'b0, mb};
                m_h   = {1'b0, ma[3:0]} + {1'b0, mb[3:0]};
                m_r   = m_sum[7:0];
                m_f[FC] = m_sum[8];
                m_f[FV] = (ma[7] == mb[7]) && (m_r[7] != ma[7]);
                m_f[FH] = m_h[4];
                m_f[FD] = 1'b0;
            end
            ALU2_CP: begin
                m_sum = {1'b0, ma} - {1'b0, mb};
                m_r   = m_sum[7:0];
                m_f[FC] = m_sum[8];
                m_f[FV] = (ma[7] != mb[7]) && (m_r[7] != ma[7]);
            end
            ALU2_TM:  begin m_r = ma & mb;  m_f[FV] = 1'b0; end
            ALU2_TCM: begin m_r = ~ma & mb; m_f[FV] = 1'b0; end
            default:  m_r = ma ^ mb;
        endcase
        if (bus.alu_mode != ALU1_LD) begin
            m_f[FS] = m_r[7];
            if (bus.alu_mode == ALU1_INCW || bus.alu_mode == ALU1_DECW)
                m_f[FZ] = (m_r == 8'h00) && bus.alu_flags[FZ];
            else
                m_f[FZ] = (m_r == 8'h00);
        end
        bus.alu_out       = m_r;
        bus.alu_out_flags = m_f;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one op at a negedge and returns latency and strobes seen in the done cycle.
    task automatic run_op(input logic [4:0] o, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] b, output int lat, output logic wl, output logic wh);
        bus.op = o; bus.a_lo = lo; bus.a_hi = hi; bus.b_in = b; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        wl = bus.wr_lo;
        wh = bus.wr_hi;
    endtask

    int   lat;
    logic wl, wh;
    logic seen;

    initial begin
        bus.start = 1'b0; bus.op = 5'h00; bus.a_lo = 8'h00; bus.a_hi = 8'h00;
        bus.b_in = 8'h00; bus.flags_we = 1'b0; bus.flags_in = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy",  {15'd0, bus.busy}, 16'd0);
        check("rst_done",  {14'd0, bus.done, bus.wr_lo | bus.wr_hi}, 16'd0);
        check("rst_res",   {bus.res_hi, bus.res_lo}, 16'h0000);
        check("rst_flags", {8'h00, bus.flags}, 16'h0000);

        run_op(ALU1_INCW, 8'hFF, 8'h12, 8'h00, lat, wl, wh);
        check("incw_lat",   16'(lat), 16'd3);
        check("incw_wr",    {14'd0, wl, wh}, 16'b11);
        check("incw_res",   {bus.res_hi, bus.res_lo}, 16'h1300);
        check("incw_flags", {8'h00, bus.flags}, 16'h0000);
        @(negedge clk);
        check("incw_pulse", {14'd0, bus.done, bus.busy}, 16'd0);

        run_op(ALU1_DECW, 8'h01, 8'h00, 8'h00, lat, wl, wh);
        check("decw0_res",   {bus.res_hi, bus.res_lo}, 16'h0000);
        check("decw0_flags", {8'h00, bus.flags}, 16'h0040);
        @(negedge clk);
        run_op(ALU1_DECW, 8'h00, 8'h80, 8'h00, lat, wl, wh);
        check("decw1_res",   {bus.res_hi, bus.res_lo}, 16'h7FFF);
        check("decw1_flags", {8'h00, bus.flags}, 16'h0010);
        @(negedge clk);

        run_op(ALU2_ADD, 8'h15, 8'h00, 8'h27, lat, wl, wh);
        check("add_lat",   16'(lat), 16'd2);
        check("add_wr",    {14'd0, wl, wh}, 16'b10);
        check("add_res",   {bus.res_hi, bus.res_lo}, 16'h7F3C);
        check("add_flags", {8'h00, bus.flags}, 16'h0000);
        @(negedge clk);

        run_op(ALU1_DA, 8'h3C, 8'h00, 8'h00, lat, wl, wh);
        check("da_lat",   16'(lat), 16'(DA_LAT));
        check("da_res",   {8'h00, bus.res_lo}, 16'h0042);
        check("da_flags", {8'h00, bus.flags}, 16'h0000);
        @(negedge clk);
        run_op(ALU1_DA, 8'h9A, 8'h00, 8'h00, lat, wl, wh);
        check("da9a_res",   {8'h00, bus.res_lo}, {8'h00, DA9A_RES});
        check("da9a_flags", {8'h00, bus.flags}, {8'h00, DA9A_FLG});
        @(negedge clk);

        run_op(ALU2_CP, 8'h10, 8'h00, 8'h20, lat, wl, wh);
        check("cp_lat",   16'(lat), 16'd2);
        check("cp_wr",    {14'd0, wl, wh}, 16'b00);
        check("cp_res",   {8'h00, bus.res_lo}, 16'h00F0);
        check("cp_flags", {8'h00, bus.flags}, 16'h00A0);
        @(negedge clk);

        // flags_we lands on the ADD flag update; a start while busy must be dropped.
        bus.op = ALU2_ADD; bus.a_lo = 8'h15; bus.b_in = 8'h27; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flags_we = 1'b1; bus.flags_in = 8'hA5;
        bus.op = ALU1_INCW; bus.a_lo = 8'h00; bus.a_hi = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bus.flags_we = 1'b0; bus.start = 1'b0;
        check("we_done",  {15'd0, bus.done}, 16'd1);
        check("we_flags", {8'h00, bus.flags}, 16'h00A5);
        check("we_res",   {8'h00, bus.res_lo}, 16'h003C);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | bus.done | bus.busy;
        end
        check("busy_start_ignored", {15'd0, seen}, 16'd0);

        // Reset asserted while INCW is in its second pass.
        bus.op = ALU1_INCW; bus.a_lo = 8'hFF; bus.a_hi = 8'h12; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_ctl",   {12'd0, bus.busy, bus.done, bus.wr_lo, bus.wr_hi}, 16'd0);
        check("mid_rst_res",   {bus.res_hi, bus.res_lo}, 16'h0000);
        check("mid_rst_flags", {8'h00, bus.flags}, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | bus.done | bus.wr_lo | bus.wr_hi;
        end
        check("mid_rst_no_done", {15'd0, seen}, 16'd0);

        run_op(ALU2_ADD, 8'h01, 8'h00, 8'h02, lat, wl, wh);
        check("post_rst_lat", 16'(lat), 16'd2);
        check("post_rst_res", {bus.res_hi, bus.res_lo}, 16'h0003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Pass sequencer between the instruction decoder and the combinational `Alu`. It latches an operation request and drives `Alu` mode, operands and flags for one or two passes. Two passes are used for 16-bit `INCW`/`DECW` (low byte, then high byte) and for `DA` (low-nibble correction, then high-nibble correction). It owns the architectural flag register and emits register-file write strobes with the final results.

## Interface
Parameters: none (ALU mode codes come from `alu.vh`; flag bit indices come from `flags.vh`).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only while `busy`=0.
- `op`  in  5  ALU mode code (`ALU1_*`/`ALU2_*`).
- `a_lo`  in  8  operand A, or the low byte of the word operand.
- `a_hi`  in  8  high byte of the word operand; used only by `INCW`/`DECW`.
- `b_in`  in  8  operand B; used only by `ALU2_*` ops.
- `flags_we`  in  1  direct write of the flag register (CPU write to FC).
- `flags_in`  in  8  data for `flags_we`.
- `busy`  out  1  high while an op is in progress.
- `done`  out  1  one-cycle completion pulse.
- `wr_lo`, `wr_hi`  out  1  write strobes; only ever high in the `done` cycle.
- `res_lo`, `res_hi`  out  8  result bytes; hold their value until the next completion.
- `flags`  out  8  architectural flag register.
- `alu_mode`  out  5  to `Alu.mode`.
- `alu_a`, `alu_b`  out  8  to `Alu.a` and `Alu.b`.
- `alu_flags`  out  8  to `Alu.flags`.
- `alu_out`  in  8  from `Alu.out`.
- `alu_out_flags`  in  8  from `Alu.outFlags`.

## Operation
- States: `IDLE`, `P1`, `P2`, `FIN`.
- Transitions:
  - `IDLE`→`P1` on `start`; `op`, `a_lo`, `a_hi` and `b_in` are latched.
  - `P1`→`P2` for `ALU1_INCW`, `ALU1_DECW` and `ALU1_DA`.
  - `P1`→`FIN` for all other ops.
  - `P2`→`FIN`, then `FIN`→`IDLE`.
- `P1` drive:
  - `INCW`: mode `ALU1_INC`, a=`a_lo`.
  - `DECW`: mode `ALU1_DEC`, a=`a_lo`.
  - Otherwise: mode=`op`, a=`a_lo`, b=`b_in`.
  - `alu_flags`=`flags` in every case.
- End of `P1`: capture `alu_out` into `tmp`; capture `alu_out_flags` into `tflags`.
- `P2` drive:
  - `INCW`/`DECW`: mode=`op`, a=`a_hi`, b=`tmp`.
  - `DA`: mode `ALU1_DA_H`, a=`tmp`.
  - `alu_flags`=`tflags` in every case.
- End of the last pass:
  - `flags` ← `alu_out_flags` (pass-1 flags are discarded for word ops).
  - Word ops: `res_lo` ← `tmp`, `res_hi` ← `alu_out`.
  - All other ops: `res_lo` ← `alu_out`; `res_hi` is unchanged.
- `FIN`: `done`=1.
  - `wr_lo`=1 unless op is `ALU2_CP`, `ALU2_TM` or `ALU2_TCM` (flags-only ops).
  - `wr_hi`=1 only for `INCW`/`DECW`.
- Outside `P1`/`P2`: `alu_mode`=`ALU1_LD`, a=`a_lo`, b=0, `alu_flags`=`flags`.
- `flags_we` updates `flags` in any state. When it coincides with the sequencer's flag update, `flags_we` wins.
- Unrecognised op codes run as single-pass ops; the result is whatever `Alu` produces.

## Timing
- `start` sampled in cycle 0.
- Single-pass ops: `P1` in cycle 1; `done`, strobes and new `flags` visible in cycle 2 (latency 2).
- Two-pass ops: `P2` in cycle 2; `done` in cycle 3 (latency 3).
- `busy` = state≠`IDLE`, so it is high from cycle 1 through the `done` cycle. `start` while `busy` is ignored; it is not queued.
- Back-to-back ops: the next `start` is accepted in the cycle after `done`.
- Reset (async, any state):
  - state `IDLE`.
  - `busy`, `done`, `wr_lo`, `wr_hi` = 0.
  - `res_lo`, `res_hi`, `tmp`, `tflags`, `flags` = 00.
  - An op in flight is abandoned with no strobes.

## Configuration
- `ALU_SEQ_DA_EN` defined: `ALU1_DA` runs two passes as described above.
- `ALU_SEQ_DA_EN` undefined:
  - `ALU1_DA` and `ALU1_DA_H` are single-pass pass-throughs with latency 2.
  - The decoder must issue both passes itself.
  - The `tflags` path is used only by word ops.

## Test plan
- `INCW`, a_hi/a_lo=12/FF, flags=00 → `done` in cycle 3; res=13/00; `wr_lo`=`wr_hi`=1; Z=0, S=0, V=0.
- `DECW`, 80/00 → res=7F/FF; V=1, S=0, Z=0. `DECW`, 00/01 → res=00/00; Z=1.
- `ADD` 15+27 (flags C=H=D=0), result 3C, then `DA` (`ALU_SEQ_DA_EN` defined) → `res_lo`=42; C=0; `done` in cycle 3.
- `CP` a=10, b=20 → `done` in cycle 2; `wr_lo`=`wr_hi`=0; C=1, S=1, Z=0; `res_lo`=F0.
- `flags_we`=1, `flags_in`=A5, asserted in the same cycle as the `ADD` final-pass flag update → `flags`=A5. A second `start` while `busy` is ignored.
- `reset_n` pulsed low during `P2` of `INCW` → no `done`, no strobes; all outputs 00. A new `start` is accepted after release.
